// File: rtl/interrupt_controller.sv
// Multi-source interrupt front end: rising-edge capture into a pending register,
// mask filtering, fixed-priority arbitration and a single req/ack/EOI handshake.
module interrupt_controller #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_BITS   = 8,
    parameter int ID_BITS     = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   mask_wr_en,
    input  logic [DATA_BITS-1:0]   mask_wr_data,
    input  logic                   eoi_wr_en,
    output logic                   int_req,
    input  logic                   int_ack,
    output logic [ID_BITS-1:0]     active_id,
    output logic                   active_valid,
    output logic [NUM_SOURCES-1:0] pending,
    output logic [NUM_SOURCES-1:0] mask
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NUM_SOURCES-1:0] irq_prev;
    logic [NUM_SOURCES-1:0] edges;
    logic [NUM_SOURCES-1:0] eligible;
    logic [NUM_SOURCES-1:0] ack_clr;
    logic [ID_BITS-1:0]     winner;
    logic [ID_BITS-1:0]     id_next;

    generate
        if (DATA_BITS > NUM_SOURCES) begin : g_wide_data
            logic mask_data_unused;
            assign mask_data_unused = ^mask_wr_data[DATA_BITS-1:NUM_SOURCES];
        end
    endgenerate

    assign edges    = irq_src & ~irq_prev;
    assign eligible = pending & mask;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_BITS'(i);
        end
    end

    always_comb begin
        state_next = state;
        id_next    = active_id;
        ack_clr    = '0;
        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    state_next = REQ;
                    id_next    = winner;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_next = SERVICE;
                    for (int i = 0; i < NUM_SOURCES; i++) begin
                        if (active_id == ID_BITS'(i)) ack_clr[i] = 1'b1;
                    end
                end
            end
            SERVICE: begin
                if (eoi_wr_en) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // irq_prev resets high so a line already asserted at reset exit is not an event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_prev     <= '1;
            pending      <= '0;
            mask         <= '0;
            active_id    <= '0;
            int_req      <= 1'b0;
            active_valid <= 1'b0;
        end else begin
            irq_prev     <= irq_src;
            pending      <= (pending & ~ack_clr) | edges;
            if (mask_wr_en) mask <= mask_wr_data[NUM_SOURCES-1:0];
            active_id    <= id_next;
            int_req      <= (state_next == REQ);
            active_valid <= (state_next == SERVICE);
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_interrupt_controller;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] irq_src;
    logic         mask_wr_en;
    logic [7:0]   mask_wr_data;
    logic         eoi_wr_en;
    logic         int_req;
    logic         int_ack;
    logic [1:0]   active_id;
    logic         active_valid;
    logic [N-1:0] pending;
    logic [N-1:0] mask;

    int n_cmp = 0;
    int n_bad = 0;

    interrupt_controller #(.NUM_SOURCES(N), .DATA_BITS(8), .ID_BITS(2)) dut (
        .clk(clk), .reset_n(reset_n), .irq_src(irq_src),
        .mask_wr_en(mask_wr_en), .mask_wr_data(mask_wr_data), .eoi_wr_en(eoi_wr_en),
        .int_req(int_req), .int_ack(int_ack), .active_id(active_id),
        .active_valid(active_valid), .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 = nothing outstanding, 1 = request offered, 2 = in service.
    int           m_phase = 0;
    int           m_id    = 0;
    logic [N-1:0] m_pend  = '0;
    logic [N-1:0] m_mask  = '0;
    logic [N-1:0] m_prev  = '1;
    logic [N-1:0] m_rise;
    bit           m_init  = 1'b0;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_phase = 0; m_id = 0; m_pend = '0; m_mask = '0; m_prev = '1; m_init = 1'b1;
        end else begin
            m_rise = irq_src & ~m_prev;
            if (m_phase == 0 && (m_pend & m_mask) != '0) begin
                m_id = lowest(m_pend & m_mask);
                m_phase = 1;
            end else if (m_phase == 1 && int_ack) begin
                m_pend[m_id] = 1'b0;
                m_phase = 2;
            end else if (m_phase == 2 && eoi_wr_en) begin
                m_phase = 0;
            end
            m_pend = m_pend | m_rise;
            m_prev = irq_src;
            if (mask_wr_en) m_mask = mask_wr_data[N-1:0];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            check("model.int_req", int'(int_req), int'(m_phase == 1));
            check("model.active_valid", int'(active_valid), int'(m_phase == 2));
            check("model.active_id", int'(active_id), m_id);
            check("model.pending", int'(pending), int'(m_pend));
            check("model.mask", int'(mask), int'(m_mask));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_mask(input logic [7:0] d);
        mask_wr_en = 1'b1; mask_wr_data = d; step(); mask_wr_en = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] s);
        irq_src = s; step(); irq_src = '0; step();
    endtask

    task automatic ack();
        int_ack = 1'b1; step(); int_ack = 1'b0;
    endtask

    task automatic eoi();
        eoi_wr_en = 1'b1; step(); eoi_wr_en = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 20; i++) begin
            if (int_req) break;
            step();
        end
        check(name, int'(int_req), 1);
    endtask

    initial begin
        reset_n = 1'b0; irq_src = 4'b0001; mask_wr_en = 1'b0; mask_wr_data = '0;
        eoi_wr_en = 1'b0; int_ack = 1'b0;
        step(); step();
        check("rst.int_req", int'(int_req), 0);
        check("rst.active_id", int'(active_id), 0);
        check("rst.active_valid", int'(active_valid), 0);
        check("rst.pending", int'(pending), 0);
        check("rst.mask", int'(mask), 0);

        // Line held high through reset must not fire.
        reset_n = 1'b1;
        write_mask(8'hFF);
        check("mask.upper_ignored", int'(mask), 4'b1111);
        repeat (5) step();
        check("held.no_req", int'(int_req), 0);
        check("held.no_pending", int'(pending), 0);
        irq_src = '0; step(); step();
        irq_src = 4'b0001; step();
        check("rise.pending_t1", int'(pending), 4'b0001);
        check("rise.no_req_t1", int'(int_req), 0);
        step();
        check("rise.req_t2", int'(int_req), 1);
        check("rise.id", int'(active_id), 0);
        ack();
        check("ack.req_low", int'(int_req), 0);
        check("ack.valid", int'(active_valid), 1);
        check("ack.pending", int'(pending), 0);
        irq_src = '0;
        eoi();
        check("eoi.valid", int'(active_valid), 0);

        // Masked event is kept pending until enabled.
        write_mask(8'h00);
        pulse(4'b0100);
        check("masked.pending", int'(pending), 4'b0100);
        check("masked.no_req", int'(int_req), 0);
        write_mask(8'h04);
        step();
        check("unmask.req", int'(int_req), 1);
        check("unmask.id", int'(active_id), 2);
        ack();
        check("unmask.ack_pending", int'(pending), 0);
        check("unmask.ack_valid", int'(active_valid), 1);
        eoi();

        // Simultaneous sources: priority order.
        write_mask(8'h0F);
        pulse(4'b1010);
        wait_req("prio.req1");
        check("prio.id1", int'(active_id), 1);
        ack();
        check("prio.pending_after_ack", int'(pending), 4'b1000);
        check("prio.no_req_in_service", int'(int_req), 0);
        eoi();
        wait_req("prio.req3");
        check("prio.id3", int'(active_id), 3);
        ack(); eoi();

        // Higher-priority event during REQ does not re-arbitrate.
        pulse(4'b0100);
        wait_req("freeze.req2");
        pulse(4'b0001);
        check("freeze.id_held", int'(active_id), 2);
        check("freeze.req_held", int'(int_req), 1);
        check("freeze.pending", int'(pending), 4'b0101);
        ack(); eoi();
        wait_req("freeze.req0");
        check("freeze.id0", int'(active_id), 0);
        ack(); eoi();

        // Re-edges during service collapse into one pending event.
        pulse(4'b0010);
        wait_req("collapse.req_a");
        ack();
        pulse(4'b0010);
        pulse(4'b0010);
        check("collapse.pending", int'(pending), 4'b0010);
        check("collapse.no_req", int'(int_req), 0);
        eoi();
        wait_req("collapse.req_b");
        check("collapse.id", int'(active_id), 1);
        ack();
        check("collapse.cleared", int'(pending), 0);
        eoi();
        repeat (3) step();
        check("collapse.single", int'(int_req), 0);

        // Reset in the middle of service.
        write_mask(8'h01);
        pulse(4'b0111);
        wait_req("midrst.req");
        ack();
        check("midrst.pending", int'(pending), 4'b0110);
        reset_n = 1'b0; step(); reset_n = 1'b1;
        check("midrst.int_req", int'(int_req), 0);
        check("midrst.active_valid", int'(active_valid), 0);
        check("midrst.active_id", int'(active_id), 0);
        check("midrst.pending", int'(pending), 0);
        check("midrst.mask", int'(mask), 0);
        eoi(); ack();
        check("stray.int_req", int'(int_req), 0);
        check("stray.active_valid", int'(active_valid), 0);
        check("stray.pending", int'(pending), 0);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            end
            mask_wr_en   = ($urandom_range(0, 9) == 0);
            mask_wr_data = 8'($urandom);
            eoi_wr_en    = ($urandom_range(0, 5) == 0);
            int_ack      = (m_phase == 1) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 19) == 0);
            reset_n      = ($urandom_range(0, 399) != 0);
            step();
        end
        reset_n = 1'b1; mask_wr_en = 1'b0; eoi_wr_en = 1'b0; int_ack = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
